// File: rtl/led_ctrl_pkg.sv
// Shared encodings and field widths for the multi-channel LED controller.
// Mode and register-offset enums are used by the top level and by every channel.
package led_ctrl_pkg;

  localparam int BUS_W    = 32;
  localparam int ADDR_W   = 8;
  localparam int CH_IDX_W = 4;
  localparam int MODE_W   = 2;
  localparam int PERIOD_W = 8;
  localparam int DUTY_W   = 8;
  localparam int PHASE_W  = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    OFS_VALUE  = 2'd0,
    OFS_MODE   = 2'd1,
    OFS_PERIOD = 2'd2,
    OFS_DUTY   = 2'd3
  } ofs_e;

  // True when the phase counter sits on its last step; callers guarantee per != 0.
  function automatic logic phase_last(input logic [PHASE_W-1:0] ph,
                                      input logic [PERIOD_W-1:0] per);
    return ph >= (per - PERIOD_W'(1));
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: VALUE/MODE/PERIOD/DUTY registers, phase and blink state,
// mode mux and registered output slice.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        reg_sel,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic              tick,
  output logic [CH_W-1:0]   led,
  output logic [BUS_W-1:0]  rd_data
);

  ofs_e                sel;
  logic [CH_W-1:0]     value_q;
  mode_e               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [DUTY_W-1:0]   duty_q;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                blink_off_q, blink_off_d;
  logic                ctl_wr;
  logic [CH_W-1:0]     led_p0, led_p1;
  logic                unused_wr;

  assign sel       = ofs_e'(reg_sel);
  assign ctl_wr    = wr_en && (sel == OFS_MODE || sel == OFS_PERIOD);
  assign unused_wr = ^wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q  <= '0;
      mode_q   <= MODE_STATIC;
      period_q <= '0;
      duty_q   <= '0;
    end else if (wr_en) begin
      case (sel)
        OFS_VALUE:  value_q  <= wr_data[CH_W-1:0];
        OFS_MODE:   mode_q   <= mode_e'(wr_data[MODE_W-1:0]);
        OFS_PERIOD: period_q <= wr_data[PERIOD_W-1:0];
        OFS_DUTY:   duty_q   <= wr_data[DUTY_W-1:0];
        default:    ;
      endcase
    end
  end

  // Phase/blink sequencing; a MODE or PERIOD write restarts the pattern.
  always_comb begin
    phase_d     = phase_q;
    blink_off_d = blink_off_q;
    if (ctl_wr) begin
      phase_d     = '0;
      blink_off_d = 1'b0;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (period_q == '0) begin
            phase_d     = '0;
            blink_off_d = 1'b0;
          end else if (tick) begin
            if (phase_last(phase_q, period_q)) begin
              phase_d     = '0;
              blink_off_d = ~blink_off_q;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
            end
          end
        end
        MODE_PWM: begin
          if (period_q == '0 || phase_last(phase_q, period_q)) phase_d = '0;
          else                                                  phase_d = phase_q + PHASE_W'(1);
        end
        default: phase_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= '0;
      blink_off_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      blink_off_q <= blink_off_d;
    end
  end

  // Stage p0: mode mux. PERIOD=0 in PWM leaves phase at 0, so phase<DUTY is DUTY!=0.
  always_comb begin
    led_p0 = '0;
    case (mode_q)
      MODE_STATIC: led_p0 = value_q;
      MODE_BLINK:  if (!blink_off_q)     led_p0 = value_q;
      MODE_PWM:    if (phase_q < duty_q) led_p0 = value_q;
      default:     led_p0 = '0;
    endcase
  end

  // Stage p1: registered LED drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) led_p1 <= '0;
    else        led_p1 <= led_p0;
  end

  assign led = led_p1;

  always_comb begin
    rd_data = '0;
    case (sel)
      OFS_VALUE:  rd_data[CH_W-1:0]     = value_q;
      OFS_MODE:   rd_data[MODE_W-1:0]   = mode_q;
      OFS_PERIOD: rd_data[PERIOD_W-1:0] = period_q;
      OFS_DUTY:   rd_data[DUTY_W-1:0]   = duty_q;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped multi-channel LED controller: address decode, blink prescaler,
// N_CH channel instances and the registered read-back path.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CH_W  = 8,
  parameter int PRESC = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    Address,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  input  logic [BUS_W-1:0]     Write_data,
  output logic [BUS_W-1:0]     Read_data,
  output logic [N_CH*CH_W-1:0] leds
);

  localparam int               PRESC_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

  logic [PRESC_W-1:0]  presc_q;
  logic                tick;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [1:0]          reg_sel;
  logic [N_CH-1:0]     wr_en;
  logic [BUS_W-1:0]    rd_bus [N_CH];
  logic [BUS_W-1:0]    rd_mux_p0;
  logic                unused_addr;

  assign ch_idx      = Address[5:2];
  assign reg_sel     = Address[1:0];
  assign unused_addr = ^Address[ADDR_W-1:6];

  // Free-running prescaler; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  presc_q <= '0;
    else if (presc_q == PRESC_LAST) presc_q <= '0;
    else                         presc_q <= presc_q + PRESC_W'(1);
  end

  assign tick = (presc_q == PRESC_LAST);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign wr_en[c] = MemWrite && (ch_idx == CH_IDX_W'(c));

    led_channel #(
      .CH_W (CH_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[c]),
      .reg_sel (reg_sel),
      .wr_data (Write_data),
      .tick    (tick),
      .led     (leds[c*CH_W +: CH_W]),
      .rd_data (rd_bus[c])
    );
  end

  // Stage p0: channel select; indices past N_CH match nothing and read as 0.
  always_comb begin
    rd_mux_p0 = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_idx == CH_IDX_W'(c)) rd_mux_p0 = rd_bus[c];
    end
  end

  // Stage p1: read data register, sampled before any same-edge write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       Read_data <= '0;
    else if (MemRead) Read_data <= rd_mux_p0;
  end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Memory-mapped multi-channel LED controller on the CPU data bus. It is the parametrised successor to the single 32-bit LED latch. It holds `N_CH` independent channels of `CH_W` bits. Each channel runs in one of four modes: static, blink, PWM or off. All registers can be read back. It decodes its own register window from the bus word address and drives the board LEDs from registered outputs.

## Interface
Parameters:
- `N_CH`, 4, number of LED channels (1–16).
- `CH_W`, 8, LED bits per channel (1–32).
- `PRESC`, 50000, clock cycles per blink tick (≥2).

Ports:
- `clk`, in, 1, system clock.
- `reset`, in, 1, asynchronous, active-low reset. One clock domain only; reset is asynchronous and active-low.
- `Address`, in, 8, word address within the block window. Bits [1:0] select the register; bits [5:2] select the channel.
- `MemWrite`, in, 1, write strobe, sampled on the rising edge.
- `MemRead`, in, 1, read strobe, sampled on the rising edge.
- `Write_data`, in, 32, write data. Only the low bits of each register are used.
- `Read_data`, out, 32, registered read data, zero-extended.
- `leds`, out, `N_CH*CH_W`, LED drive. Channel c occupies `[c*CH_W +: CH_W]`.

## Operation
- Per-channel registers, by offset:
  - 0 VALUE: `CH_W` bits.
  - 1 MODE: 2 bits. 0 STATIC, 1 BLINK, 2 PWM, 3 OFF.
  - 2 PERIOD: 8 bits.
  - 3 DUTY: 8 bits.
- All registers reset to 0, so every channel comes up in STATIC mode with VALUE 0.
- Channel index ≥ `N_CH`: writes are ignored; reads return 0.
- A write to MODE or PERIOD clears that channel's `phase` counter and `blink_off` flag. Writes to VALUE or DUTY leave them unchanged.
- Prescaler: counts 0..`PRESC-1` and wraps. `tick` is high for one cycle when the count equals `PRESC-1`.
- Each channel has an 8-bit `phase` counter and a `blink_off` flag.
- STATIC: channel output = VALUE. `phase` is held at 0.
- BLINK: `phase` advances on `tick`, counting 0..PERIOD-1.
  - On a tick with `phase`==PERIOD-1: `phase` goes to 0 and `blink_off` toggles.
  - Output = VALUE when `blink_off`=0, otherwise 0.
  - PERIOD=0: `phase` and `blink_off` are held at 0, so the output stays at VALUE.
- PWM: `phase` advances every clock, counting 0..PERIOD-1 and wrapping.
  - Output = VALUE when `phase` < DUTY, otherwise 0.
  - DUTY ≥ PERIOD gives output always on; DUTY=0 gives output always off.
  - PERIOD=0: `phase` is held at 0 and output = (DUTY≠0 ? VALUE : 0).
- OFF: output 0. `phase` is held at 0.
- Reads: `Read_data` is loaded with the addressed register, zero-extended, on the edge where `MemRead`=1. It holds its value otherwise.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Arithmetic: all counters are unsigned and wrap by explicit compare, never by overflow.

## Timing
- Write sampled at edge k: the register holds the new value after edge k. `leds` reflects it after edge k+1, i.e. one cycle of output-register latency.
- Read sampled at edge k: `Read_data` is valid after edge k.
- `leds` is registered and glitch-free. A channel output changes only on `clk` edges.
- Blink half-period = PERIOD×`PRESC` cycles. PWM period = PERIOD cycles, on-time = min(DUTY, PERIOD) cycles.
- `reset` low at any time, including mid-PWM or mid-blink:
  - `leds`, `Read_data`, all registers, prescaler, `phase` and `blink_off` clear to 0 immediately.
  - Operation resumes on the first edge after `reset` returns high.
- Prescaler runs free; it is cleared only by reset.

## Structure
- Package `led_ctrl_pkg` holds:
  - the MODE encodings (STATIC/BLINK/PWM/OFF);
  - the register offsets (VALUE/MODE/PERIOD/DUTY);
  - the field widths (PERIOD and DUTY are 8-bit).
- Sub-module `led_channel` is instantiated `N_CH` times via generate. Each instance contains:
  - its VALUE, MODE, PERIOD and DUTY registers;
  - `phase` and `blink_off`;
  - the mode mux and the output register.
  - Inputs: per-channel write enable, register select, write data, `tick`. Outputs: `leds` slice and readback bus.
- Top level contains the address decode, the prescaler and the `Read_data` mux and register.

## Test plan
- Reset, then write VALUE ch1=0xA5 → `leds[15:8]`=0xA5 one cycle after the register update; all other channels stay 0x00. Reading ch1 offset 0 returns 0x000000A5.
- `PRESC`=4. Ch0: VALUE=0xFF, PERIOD=2, MODE=BLINK → `leds[7:0]` alternates 0xFF / 0x00, each lasting 8 cycles.
- Ch2: VALUE=0x0F, PERIOD=5, DUTY=2, MODE=PWM → repeating pattern of 2 cycles 0x0F, then 3 cycles 0x00. DUTY=7 → constant 0x0F. DUTY=0 → constant 0x00.
- Write to channel index 6 with `N_CH`=4 → no register changes; a read of channel 6 returns 0. Same-edge read and write to ch0 VALUE (old 0x11, new 0x22) → `Read_data`=0x11, and a subsequent read returns 0x22.
- Assert `reset` low mid-PWM → `leds`=0 and `Read_data`=0 immediately, without waiting for a clock edge. After release, every register reads 0 and the outputs stay 0.
